// File: rtl/apb_mbridge.sv
// Multi-slave APB-style bridge: host requests run as SETUP/ACCESS with WAIT states
// and are decoded to one of NSLV memory ports; unmapped addresses complete with err.
//
// state  | meaning
// IDLE   | ready for a request; done/err pulse is visible here after a transfer
// SETUP  | one cycle; latched address is decoded
// ACCESS | WAIT+1 cycles; slave strobe and read capture on the last one
module apb_mbridge #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int NSLV        = 4,
  parameter int REGION_BITS = 12,
  parameter int WAIT        = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   trnsfr,
  output logic                   ready,
  input  logic                   wr,
  input  logic [AW-1:0]          address,
  input  logic [DW-1:0]          data_in,
  input  logic [DW/8-1:0]        strb,
  output logic [DW-1:0]          data_out,
  output logic                   done,
  output logic                   err,
  output logic [NSLV-1:0]        mem_wr,
  output logic [NSLV-1:0]        mem_rd,
  output logic [DW/8-1:0]        mem_be,
  output logic [REGION_BITS-1:0] mem_address,
  output logic [DW-1:0]          mem_data_in,
  input  logic [NSLV*DW-1:0]     mem_data_out
);

  localparam int IW   = $clog2(NSLV);
  localparam int IDXW = (IW > 0) ? IW : 1;
  localparam int BW   = DW / 8;
  localparam logic [3:0] WAIT_C = 4'(WAIT);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic [BW-1:0]     be_q, be_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              map_q, map_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DW-1:0]     dout_q, dout_d;

  logic              map_dec;
  logic [IDXW-1:0]   idx_dec;
  logic [DW-1:0]     rd_sel;
  logic [NSLV-1:0]   onehot;
  logic              fire;

  // Everything above the slave-index field must be zero for a mapped address.
  if (REGION_BITS + IW < AW) begin : g_hi
    assign map_dec = ~|addr_q[AW-1:REGION_BITS+IW];
  end else begin : g_nohi
    assign map_dec = 1'b1;
  end

  if (IW > 0) begin : g_idx
    assign idx_dec = addr_q[REGION_BITS +: IDXW];
  end else begin : g_noidx
    assign idx_dec = 1'b0;
  end

  always_comb begin
    rd_sel = '0;
    onehot = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (idx_q == IDXW'(k)) begin
        rd_sel    = mem_data_out[k*DW +: DW];
        onehot[k] = 1'b1;
      end
    end
  end

  // Strobes come straight from registered state so a reset drops them at once.
  assign fire   = (state_q == S_ACCESS) && (cnt_q == WAIT_C) && map_q;
  assign mem_wr = (fire && wr_q)  ? onehot : '0;
  assign mem_rd = (fire && !wr_q) ? onehot : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    idx_d   = idx_q;
    map_d   = map_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE: begin
        if (trnsfr) begin
          wr_d    = wr;
          addr_d  = address;
          data_d  = data_in;
          be_d    = wr ? strb : '1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        idx_d   = idx_dec;
        map_d   = map_dec;
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt_q == WAIT_C) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = ~map_q;
          if (!wr_q) dout_d = map_q ? rd_sel : '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      idx_q   <= '0;
      map_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      idx_q   <= idx_d;
      map_q   <= map_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  assign ready       = (state_q == S_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign data_out    = dout_q;
  assign mem_be      = be_q;
  assign mem_address = addr_q[REGION_BITS-1:0];
  assign mem_data_in = data_q;

endmodule

// File: tb/tb_apb_mbridge.sv
// Bench for apb_mbridge: four instances (WAIT = 0,1,3,5) share the host inputs;
// each scenario observes one instance against a behavioural transfer model.
module tb_apb_mbridge;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic trnsfr = 1'b0;
  logic wr = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  strb = '0;

  logic        ready_a [4];
  logic [31:0] dout_a  [4];
  logic        done_a  [4];
  logic        err_a   [4];
  logic [3:0]  mwr_a   [4];
  logic [3:0]  mrd_a   [4];
  logic [3:0]  mbe_a   [4];
  logic [11:0] madr_a  [4];
  logic [31:0] mdin_a  [4];
  logic [31:0] slv_val [4];
  logic [31:0] exp_dout [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int wv(input int s);
    case (s)
      0: return 0;
      1: return 1;
      2: return 3;
      default: return 5;
    endcase
  endfunction

  // Slave k answers its stored word xor the offset it is given.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [127:0] mdo;
    assign mdo = {slv_val[3] ^ {20'b0, madr_a[g]}, slv_val[2] ^ {20'b0, madr_a[g]},
                  slv_val[1] ^ {20'b0, madr_a[g]}, slv_val[0] ^ {20'b0, madr_a[g]}};
    apb_mbridge #(.AW(32), .DW(32), .NSLV(4), .REGION_BITS(12),
                  .WAIT((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 5)) u_dut (
      .clk(clk), .rst_n(rst_n), .trnsfr(trnsfr), .ready(ready_a[g]), .wr(wr),
      .address(address), .data_in(data_in), .strb(strb), .data_out(dout_a[g]),
      .done(done_a[g]), .err(err_a[g]), .mem_wr(mwr_a[g]), .mem_rd(mrd_a[g]),
      .mem_be(mbe_a[g]), .mem_address(madr_a[g]), .mem_data_in(mdin_a[g]),
      .mem_data_out(mdo)
    );
  end

  // Observations of the last transfer, recorded by run_xfer.
  int          n_str, str_c, n_done, done_c, rdy_bad;
  logic        acc_ok, done_err;
  logic [3:0]  str_wr, str_rd, str_be;
  logic [11:0] str_adr, fin_adr;
  logic [31:0] str_din, done_dout, fin_dout;

  int          d_sel [5] = '{0, 2, 2, 2, 1};
  logic        d_w   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] d_a   [5] = '{32'h1004, 32'h3010, 32'h4000, 32'h0000, 32'h2ABC};
  logic [31:0] d_d   [5] = '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D};
  logic [3:0]  d_b   [5] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0};

  task automatic run_xfer(input int s, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    trnsfr = 1'b1; wr = w; address = a; data_in = d; strb = b;
    acc_ok = ready_a[s];
    @(posedge clk);
    #1;
    trnsfr = 1'b0; wr = 1'($urandom); address = $urandom; data_in = $urandom;
    strb = 4'($urandom);
    n_str = 0; n_done = 0; rdy_bad = 0; str_c = -1; done_c = -1;
    str_wr = '0; str_rd = '0; str_be = '0; str_adr = '0; str_din = '0;
    done_err = 1'b0; done_dout = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if ((mwr_a[s] | mrd_a[s]) != 4'b0) begin
        if (n_str == 0) begin
          str_c = c; str_wr = mwr_a[s]; str_rd = mrd_a[s]; str_be = mbe_a[s];
          str_adr = madr_a[s]; str_din = mdin_a[s];
        end
        n_str++;
      end
      if (done_a[s]) begin
        if (n_done == 0) begin done_c = c; done_err = err_a[s]; done_dout = dout_a[s]; end
        n_done++;
      end
      if (c <= wv(s) + 1 && ready_a[s]) rdy_bad++;
    end
    fin_adr = madr_a[s];
    fin_dout = dout_a[s];
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin slv_val[k] = '0; exp_dout[k] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ((mwr_a[i] | mrd_a[i]) !== 4'b0) begin
          errors++; $display("FAIL reset_strobe inst %0d: got wr %b rd %b want 0", i, mwr_a[i], mrd_a[i]);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ready_a[i] !== 1'b1 || done_a[i] !== 1'b0 || err_a[i] !== 1'b0) begin
        errors++; $display("FAIL reset_ctrl inst %0d: got ready %b done %b err %b want 1 0 0", i, ready_a[i], done_a[i], err_a[i]);
      end
      checks++;
      if (dout_a[i] !== 32'h0 || mdin_a[i] !== 32'h0) begin
        errors++; $display("FAIL reset_data inst %0d: got dout %h mdin %h want 0", i, dout_a[i], mdin_a[i]);
      end
      checks++;
      if (mbe_a[i] !== 4'h0 || madr_a[i] !== 12'h0) begin
        errors++; $display("FAIL reset_mem inst %0d: got be %h addr %h want 0", i, mbe_a[i], madr_a[i]);
      end
    end
  endtask

  task automatic test_transfers;
    int s; logic w; logic [31:0] a, d, r; logic [3:0] b;
    logic [1:0] idx; logic mapped; logic [3:0] e_oh;
    for (int n = 0; n < 45; n++) begin
      for (int k = 0; k < 4; k++) slv_val[k] = $urandom;
      if (n < 5) begin
        s = d_sel[n]; w = d_w[n]; a = d_a[n]; d = d_d[n]; b = d_b[n];
        if (n == 1) slv_val[3] = 32'h12345678 ^ 32'h010;
      end else begin
        s = int'($urandom_range(0, 3)); w = 1'($urandom); d = $urandom; b = 4'($urandom);
        r = $urandom;
        a = ($urandom_range(0, 3) == 0) ? r : (r & 32'h3FFF);
      end
      idx = a[13:12];
      mapped = (a[31:14] == 18'h0);
      e_oh = 4'b0001 << idx;
      run_xfer(s, w, a, d, b);
      if (!w) for (int k = 0; k < 4; k++) exp_dout[k] = mapped ? (slv_val[idx] ^ {20'b0, a[11:0]}) : 32'h0;
      checks++;
      if (acc_ok !== 1'b1 || rdy_bad !== 0) begin
        errors++; $display("FAIL ready n%0d: got accept_ready %b busy_ready_cycles %0d want 1 0", n, acc_ok, rdy_bad);
      end
      checks++;
      if (n_str !== (mapped ? 1 : 0)) begin
        errors++; $display("FAIL strobe_count n%0d addr %h: got %0d want %0d", n, a, n_str, mapped ? 1 : 0);
      end
      if (mapped) begin
        checks++;
        if (str_c !== wv(s) + 1) begin
          errors++; $display("FAIL strobe_cycle n%0d: got %0d want %0d", n, str_c, wv(s) + 1);
        end
        checks++;
        if (str_wr !== (w ? e_oh : 4'b0) || str_rd !== (w ? 4'b0 : e_oh)) begin
          errors++; $display("FAIL strobe_sel n%0d: got wr %b rd %b want wr %b rd %b", n, str_wr, str_rd, w ? e_oh : 4'b0, w ? 4'b0 : e_oh);
        end
        checks++;
        if (str_adr !== a[11:0] || str_be !== (w ? b : 4'hF)) begin
          errors++; $display("FAIL strobe_addr_be n%0d: got %h/%h want %h/%h", n, str_adr, str_be, a[11:0], w ? b : 4'hF);
        end
        if (w) begin
          checks++;
          if (str_din !== d) begin
            errors++; $display("FAIL strobe_wdata n%0d: got %h want %h", n, str_din, d);
          end
        end
      end
      checks++;
      if (n_done !== 1 || done_c !== wv(s) + 2) begin
        errors++; $display("FAIL done_timing n%0d: got count %0d cycle %0d want 1 %0d", n, n_done, done_c, wv(s) + 2);
      end
      checks++;
      if (done_err !== !mapped) begin
        errors++; $display("FAIL err n%0d addr %h: got %b want %b", n, a, done_err, !mapped);
      end
      checks++;
      if (done_dout !== exp_dout[s] || fin_dout !== exp_dout[s]) begin
        errors++; $display("FAIL data_out n%0d: got %h held %h want %h", n, done_dout, fin_dout, exp_dout[s]);
      end
      checks++;
      if (fin_adr !== a[11:0]) begin
        errors++; $display("FAIL addr_hold n%0d: got %h want %h", n, fin_adr, a[11:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int nd = 0;
    logic e_act;
    @(negedge clk);
    trnsfr = 1'b1; wr = 1'b1; address = 32'h2008; data_in = 32'h55AA00FF; strb = 4'h3;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      e_act = (c % 4 == 3) && (c < 12);
      if (done_a[1]) nd++;
      checks++;
      if (done_a[1] !== e_act) begin
        errors++; $display("FAIL b2b_done c%0d: got %b want %b", c, done_a[1], e_act);
      end
      checks++;
      if (ready_a[1] !== ((c % 4 == 3) || c >= 12)) begin
        errors++; $display("FAIL b2b_ready c%0d: got %b want %b", c, ready_a[1], (c % 4 == 3) || c >= 12);
      end
      checks++;
      if (mwr_a[1] !== ((c % 4 == 2 && c < 12) ? 4'b0100 : 4'b0000)) begin
        errors++; $display("FAIL b2b_strobe c%0d: got %b", c, mwr_a[1]);
      end
      if (c == 8) trnsfr = 1'b0;
    end
    checks++;
    if (nd !== 3) begin
      errors++; $display("FAIL b2b_count: got %0d want 3", nd);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int ns = 0, nd = 0;
    @(negedge clk);
    trnsfr = 1'b1; wr = 1'b1; address = 32'h1100; data_in = 32'hA5A5A5A5; strb = 4'hF;
    @(posedge clk);
    #1 trnsfr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready_a[3] !== 1'b1 || mwr_a[3] !== 4'b0) begin
          errors++; $display("FAIL rst_mid_async: got ready %b wr %b want 1 0", ready_a[3], mwr_a[3]);
        end
      end
      if (c == 4) rst_n = 1'b1;
      if (mwr_a[3] != 4'b0) ns++;
      if (done_a[3]) nd++;
      if (c == 5) begin
        checks++;
        if (madr_a[3] !== 12'h0 || ready_a[3] !== 1'b1) begin
          errors++; $display("FAIL rst_mid_state: got addr %h ready %b want 0 1", madr_a[3], ready_a[3]);
        end
      end
    end
    checks++;
    if (ns !== 0 || nd !== 0) begin
      errors++; $display("FAIL rst_mid_abort: got strobes %0d dones %0d want 0 0", ns, nd);
    end
    for (int k = 0; k < 4; k++) exp_dout[k] = '0;
    slv_val[0] = $urandom;
    run_xfer(3, 1'b0, 32'h0234, 32'h0, 4'h0);
    checks++;
    if (n_str !== 1 || str_rd !== 4'b0001 || str_c !== 6) begin
      errors++; $display("FAIL rst_mid_next_strobe: got count %0d rd %b cycle %0d want 1 0001 6", n_str, str_rd, str_c);
    end
    checks++;
    if (n_done !== 1 || done_err !== 1'b0 || done_dout !== (slv_val[0] ^ 32'h234)) begin
      errors++; $display("FAIL rst_mid_next_done: got count %0d err %b data %h want 1 0 %h", n_done, done_err, done_dout, slv_val[0] ^ 32'h234);
    end
  endtask

  initial begin
    test_reset();
    test_transfers();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_mbridge.md
# apb_mbridge

Parametrised multi-slave APB bridge: the next generation of the single master/single slave bridge. It accepts host transfer requests, runs them as APB SETUP/ACCESS sequences with configurable wait states, and decodes each address to one of NSLV memory-style slave ports. Unmapped addresses complete with an error flag instead of hanging. It sits between a host request interface and a bank of synchronous memories/register files.

## Interface
- AW, 32: host address width in bits.
- DW, 32: data width; multiple of 8.
- NSLV, 4: number of slave ports; power of two, 1..16.
- REGION_BITS, 12: byte-offset bits per slave region. Slave index = address[REGION_BITS +: log2(NSLV)].
- WAIT, 0: wait states per access, 0..15. The ACCESS phase lasts WAIT+1 cycles.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- trnsfr  in  1  transfer request; accepted on an edge where trnsfr=1 and ready=1.
- ready  out  1  bridge can accept a request (IDLE).
- wr  in  1  1=write, 0=read; sampled at acceptance.
- address  in  AW  byte address; sampled at acceptance.
- data_in  in  DW  write data; sampled at acceptance.
- strb  in  DW/8  write byte strobes; sampled at acceptance.
- data_out  out  DW  read data; updated in the done cycle and held until the next done.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = unmapped address.
- mem_wr  out  NSLV  one-hot write strobe per slave.
- mem_rd  out  NSLV  one-hot read strobe per slave.
- mem_be  out  DW/8  byte enables: latched strb for writes, all ones for reads.
- mem_address  out  REGION_BITS  latched address[REGION_BITS-1:0].
- mem_data_in  out  DW  latched write data.
- mem_data_out  in  NSLV*DW  read data; slave k occupies bits [k*DW +: DW]. Sampled on the edge ending the strobe cycle.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: ready=1. On accept, latch wr, address, data_in and strb, then go to SETUP.
  - SETUP: lasts 1 cycle; the address is decoded here. Then go to ACCESS and clear the wait counter.
  - ACCESS: the counter increments each cycle. When counter==WAIT, this is the final cycle: assert the strobe, capture read data, and go to IDLE with done registered high.
- Decode rule: mapped iff address bits [AW-1 : REGION_BITS+log2(NSLV)] are all zero.
  - Mapped: in the final ACCESS cycle only, mem_wr[idx] or mem_rd[idx] = 1 and all other strobe bits are 0.
  - Unmapped: no strobe is ever asserted. done comes with err=1, and a read returns data_out=0. Latency is unchanged.
- Writes with strb=0 still pulse mem_wr, with mem_be=0.
- Write completion leaves data_out unchanged.
- trnsfr while ready=0 is ignored, not queued.
- Input changes after acceptance have no effect on the transfer in flight.
- mem_address, mem_be and mem_data_in hold their latched values between transfers.

## Timing
- Reset (async assert, sync release): state=IDLE, ready=1. All of the following are 0: done, err, data_out, mem_wr, mem_rd, mem_be, mem_address, mem_data_in.
- Reset mid-transfer aborts immediately; no done is produced and strobes drop asynchronously.
- Accept edge = E0.
  - SETUP is cycle E0..E1.
  - ACCESS is cycles E1..E(2+WAIT).
  - The strobe is high during cycle E(1+WAIT)..E(2+WAIT).
  - done is high during E(2+WAIT)..E(3+WAIT), with state back in IDLE.
- A new request may be accepted on the edge ending the done cycle. Back-to-back throughput is one transfer per WAIT+3 cycles.
- done and err are registered outputs. mem_wr and mem_rd are decoded from registered state and counter.

## Test plan
- Reset, then idle for 5 cycles -> ready=1 and all other outputs 0; no strobes.
- WAIT=0, NSLV=4: write addr 0x1004, data 0xDEADBEEF, strb 0xF -> mem_wr=4'b0010 for exactly 1 cycle, 2 cycles after acceptance, with mem_address=0x004, mem_be=0xF, mem_data_in=0xDEADBEEF. done follows in the next cycle with err=0.
- WAIT=3: read addr 0x3010, slave 3 returns 0x12345678 -> mem_rd=4'b1000 for exactly 1 cycle, 5 cycles after acceptance. data_out=0x12345678 with done, err=0.
- Read addr 0x4000 (unmapped) -> no mem_rd/mem_wr; done with err=1 and data_out=0 at the normal latency. A following mapped read at 0x0000 completes with err=0.
- Back-to-back: trnsfr held high for 3 requests (WAIT=1) -> exactly 3 done pulses spaced 4 cycles apart, ready=0 between acceptances, and the extra trnsfr cycles are ignored.
- rst_n pulsed low during ACCESS of a write with WAIT=5 -> no mem_wr and no done; ready=1 after release; the next transfer completes normally.
